cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//  Miss-handling controller in front of the 2-way set-associative, write-back, LRU data cache.
//  Accepts one CPU load/store at a time and runs a hit lookup.
//  On a miss it writes back a dirty victim line word by word, then refills the line from memory.
//  Sits between the CPU memory stage and the cache array; also drives the main-memory port.
// PARAMETERS
//  ADDR_BITS            32  address width
//  TAG_BITS             23  tag field, addr[31:9]
//  SET_INDEX_WIDTH       5  set index, addr[8:4]
//  ELEMENT_WORDS_WIDTH   2  word-in-line index, addr[3:2]; 4 words per line
//  WORD_BYTES_WIDTH      2  byte offset, addr[1:0]
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  cpu_req        in   1   request strobe; sampled only in IDLE
//  cpu_we         in   1   1=store, 0=load
//  cpu_addr       in   32  byte address
//  cpu_u_b_h_w    in   3   {unsigned, word, half}; RV32I LB/LH/LW/LBU/LHU/SB/SH/SW encoding
//  cpu_din        in   32  store data
//  cpu_dout       out  32  load data; valid while cpu_ack=1
//  cpu_ack        out  1   one-cycle pulse: request complete
//  cpu_busy       out  1   1 in every state except IDLE
//  cache_addr     out  32  address to cache array
//  cache_load     out  1   read with LRU refresh
//  cache_store    out  1   fill one word into LRU way; set valid, clear dirty
//  cache_edit     out  1   CPU write; set dirty
//  cache_invalid  out  1   reserved; held 0
//  cache_u_b_h_w  out  3   width select to cache
//  cache_din      out  32  data to cache
//  cache_hit/valid/dirty  in 1  from cache, registered; one cycle after cache_addr
//  cache_tag      in   23  victim tag from cache, registered
//  cache_dout     in   32  from cache, registered; victim word when cache_load=0
//  mem_cs, mem_we out  1   memory select / write
//  mem_addr       out  32  word-aligned memory address
//  mem_dout       out  32  write data to memory
//  mem_din        in   32  read data from memory
//  mem_ack        in   1   memory completion, one cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, word counter=0.
//  Reset values: all outputs 0, including cpu_ack, cpu_busy, mem_cs and all cache strobes.
//  Request capture: in IDLE, cpu_req=1 latches addr, we, u_b_h_w and din; go to LOOKUP.
//  While busy, cpu_* inputs are ignored.
//  States:
//   LOOKUP: cache_addr=req addr; all cache strobes 0 -> TAG.
//   TAG, hit: drive cache_load (load) or cache_edit (store) with cache_u_b_h_w=req width and cache_din=req din -> RESP.
//   TAG, miss: latch cache_tag as victim tag.
//     If cache_valid & cache_dirty -> WB_RD with cnt=0; otherwise -> FILL with cnt=0.
//   WB_RD: cache_addr={req tag, index, cnt, 2'b00}, strobes 0 -> WB_WR.
//   WB_WR: mem_cs=1, mem_we=1, mem_addr={victim tag, index, cnt, 00}, mem_dout=cache_dout.
//     Capture cache_dout on WB_WR entry; hold all signals stable until mem_ack.
//     On ack: cnt++; if cnt was 3 -> FILL with cnt=0, else -> WB_RD.
//   FILL: mem_cs=1, mem_we=0, mem_addr={req tag, index, cnt, 00}.
//     On mem_ack, the same cycle: cache_store=1, cache_addr=mem_addr, cache_din=mem_din, cache_u_b_h_w=3'b010.
//     cnt++; if cnt was 3 -> LOOKUP (replay; now hits and refreshes LRU).
//   RESP: cpu_ack=1; cpu_dout=cache_dout on loads, 0 on stores -> IDLE.
//  Latency: hit = cpu_ack 3 cycles after capture.
//  Miss latency adds 4 memory transfers (clean victim) or 8 (dirty victim), plus the replay.
//  LRU refresh only on the final hit; a fill never touches recent bits, so all 4 words land in one way.
//  Victim valid=0 or dirty=0: no write-back.
//  mem_ack is ignored in states other than WB_WR and FILL.
//  Reset during WB/FILL abandons the transfer: mem_cs drops immediately, partial line stays valid.
// STRUCTURE
//  Field widths and slices come from the shared address-define header.
//  State encoding is local parameters of this module.
//  Single module with no sub-module; 2-bit word counter and request/victim registers inline.
// TESTING
//  Clean read miss: mem[0x100..0x10C]=1,2,3,4; LW 0x104.
//    -> 4 mem reads 0x100..0x10C, replay hit, cpu_dout=2.
//  Hit load extension: line holds 0x0000_0080 at 0x100; LB 0x100 -> 0xFFFF_FF80; LBU 0x100 -> 0x0000_0080.
//  Dirty eviction: SW 0xAABBCCDD to 0x100; LW 0x1100 and LW 0x2100 (same set).
//    -> second miss writes 0x100..0x10C, word 0x100=0xAABBCCDD, before refilling.
//  Hit timing: LW to a resident line -> cpu_ack exactly 3 cycles after cpu_req capture; no mem_cs.
//  Memory stall: mem_ack delayed 5 cycles -> mem_addr/mem_we/mem_dout stable throughout, cpu_busy=1.
//  Async reset mid-FILL (after word 1) -> same cycle: mem_cs=0, cpu_busy=0.
//    Next LW to the same line completes correctly.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared address-field layout and request record for the data-cache miss controller.
package cache_ctrl_pkg;

  localparam int ADDR_BITS           = 32;
  localparam int TAG_BITS            = 23;
  localparam int SET_INDEX_WIDTH     = 5;
  localparam int ELEMENT_WORDS_WIDTH = 2;
  localparam int WORD_BYTES_WIDTH    = 2;

  localparam int INDEX_LSB = ELEMENT_WORDS_WIDTH + WORD_BYTES_WIDTH;
  localparam int TAG_LSB   = INDEX_LSB + SET_INDEX_WIDTH;

  localparam logic [2:0] UBHW_WORD = 3'b010;

  typedef struct packed {
    logic                 we;
    logic [2:0]           ubhw;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          din;
  } cpu_req_t;

  function automatic logic [ADDR_BITS-1:0] line_addr(
    input logic [TAG_BITS-1:0]            tag,
    input logic [SET_INDEX_WIDTH-1:0]     idx,
    input logic [ELEMENT_WORDS_WIDTH-1:0] word
  );
    return {tag, idx, word, {WORD_BYTES_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Miss-handling controller for the 2-way write-back data cache: hit lookup, dirty
// victim write-back, line refill from memory, then a replay lookup to finish the access.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [2:0]           cpu_u_b_h_w,
  input  logic [31:0]          cpu_din,
  output logic [31:0]          cpu_dout,
  output logic                 cpu_ack,
  output logic                 cpu_busy,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_store,
  output logic                 cache_edit,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [31:0]          cache_dout,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_dout,
  input  logic [31:0]          mem_din,
  input  logic                 mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_TAG, S_WB_RD, S_WB_WR, S_FILL, S_RESP
  } state_e;

  state_e                          state_q, state_d;
  logic [ELEMENT_WORDS_WIDTH-1:0]  cnt_q, cnt_d;
  cpu_req_t                        req_q, req_d;
  logic [TAG_BITS-1:0]             victim_q, victim_d;
  logic [31:0]                     wb_data_q, wb_data_d;
  logic                            wb_fresh_q, wb_fresh_d;

  logic [TAG_BITS-1:0]        req_tag;
  logic [SET_INDEX_WIDTH-1:0] req_idx;

  assign req_tag       = req_q.addr[ADDR_BITS-1:TAG_LSB];
  assign req_idx       = req_q.addr[TAG_LSB-1:INDEX_LSB];
  assign cache_invalid = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      victim_q   <= '0;
      wb_data_q  <= '0;
      wb_fresh_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      victim_q   <= victim_d;
      wb_data_q  <= wb_data_d;
      wb_fresh_q <= wb_fresh_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    victim_d      = victim_q;
    wb_data_d     = wb_data_q;
    wb_fresh_d    = 1'b0;
    cpu_dout      = '0;
    cpu_ack       = 1'b0;
    cpu_busy      = (state_q != S_IDLE);
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_edit    = 1'b0;
    cache_u_b_h_w = '0;
    cache_din     = '0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_dout      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_d.we   = cpu_we;
          req_d.ubhw = cpu_u_b_h_w;
          req_d.addr = cpu_addr;
          req_d.din  = cpu_din;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_addr = req_q.addr;
        state_d    = S_TAG;
      end
      S_TAG: begin
        cache_addr = req_q.addr;
        if (cache_hit) begin
          cache_load    = ~req_q.we;
          cache_edit    = req_q.we;
          cache_u_b_h_w = req_q.ubhw;
          cache_din     = req_q.din;
          state_d       = S_RESP;
        end else begin
          victim_d = cache_tag;
          cnt_d    = '0;
          state_d  = (cache_valid && cache_dirty) ? S_WB_RD : S_FILL;
        end
      end
      S_WB_RD: begin
        // A miss address returns the victim way's word, so the request tag is enough here.
        cache_addr = line_addr(req_tag, req_idx, cnt_q);
        wb_fresh_d = 1'b1;
        state_d    = S_WB_WR;
      end
      S_WB_WR: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = line_addr(victim_q, req_idx, cnt_q);
        mem_dout = wb_fresh_q ? cache_dout : wb_data_q;
        if (wb_fresh_q) wb_data_d = cache_dout;
        if (mem_ack) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3) ? S_FILL : S_WB_RD;
        end
      end
      S_FILL: begin
        mem_cs   = 1'b1;
        mem_addr = line_addr(req_tag, req_idx, cnt_q);
        if (mem_ack) begin
          cache_store   = 1'b1;
          cache_addr    = mem_addr;
          cache_din     = mem_din;
          cache_u_b_h_w = UBHW_WORD;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_LOOKUP;
        end
      end
      S_RESP: begin
        cpu_ack  = 1'b1;
        cpu_dout = req_q.we ? 32'd0 : cache_dout;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural 2-way LRU cache array and a word memory.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic [2:0]  cpu_u_b_h_w;
  logic        cpu_ack, cpu_busy;
  logic [31:0] cache_addr, cache_din;
  logic        cache_load, cache_store, cache_edit, cache_invalid;
  logic [2:0]  cache_u_b_h_w;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [22:0] cache_tag;
  logic [31:0] cache_dout;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_dout, mem_din;
  bit          mem_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_u_b_h_w(cpu_u_b_h_w),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
    .cache_edit(cache_edit), .cache_invalid(cache_invalid), .cache_u_b_h_w(cache_u_b_h_w),
    .cache_din(cache_din), .cache_hit(cache_hit), .cache_valid(cache_valid),
    .cache_dirty(cache_dirty), .cache_tag(cache_tag), .cache_dout(cache_dout),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack)
  );

  // ---------------- cache array model ----------------
  bit [22:0] c_tag   [32][2];
  bit        c_val   [32][2];
  bit        c_dirty [32][2];
  bit [31:0] c_data  [32][2][4];
  bit        c_lru   [32];

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [2:0] f, logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f[1:0])
      2'b00:   return f[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(logic [31:0] old, logic [31:0] nw, logic [2:0] f,
                                           logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (f[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = nw[7:0];
      2'b01:   if (off[1]) r[31:16] = nw[15:0]; else r[15:0] = nw[15:0];
      default: r = nw;
    endcase
    return r;
  endfunction

  wire [4:0]  ci_idx  = cache_addr[8:4];
  wire [22:0] ci_tag  = cache_addr[31:9];
  wire [1:0]  ci_w    = cache_addr[3:2];
  wire        ci_h0   = c_val[ci_idx][0] && (c_tag[ci_idx][0] == ci_tag);
  wire        ci_h1   = c_val[ci_idx][1] && (c_tag[ci_idx][1] == ci_tag);
  wire        ci_hit  = ci_h0 | ci_h1;
  wire        ci_way  = ci_h0 ? 1'b0 : (ci_h1 ? 1'b1 : c_lru[ci_idx]);
  wire [31:0] ci_word = c_data[ci_idx][ci_way][ci_w];

  always @(posedge clk) begin
    cache_hit   <= ci_hit;
    cache_valid <= c_val[ci_idx][ci_way];
    cache_dirty <= c_dirty[ci_idx][ci_way];
    cache_tag   <= c_tag[ci_idx][ci_way];
    cache_dout  <= (cache_load && ci_hit) ? ld_ext(ci_word, cache_u_b_h_w, cache_addr[1:0]) : ci_word;
    if (cache_store) begin
      c_tag[ci_idx][c_lru[ci_idx]]         <= ci_tag;
      c_val[ci_idx][c_lru[ci_idx]]         <= 1'b1;
      c_dirty[ci_idx][c_lru[ci_idx]]       <= 1'b0;
      c_data[ci_idx][c_lru[ci_idx]][ci_w]  <= cache_din;
    end
    if (cache_edit && ci_hit) begin
      c_data[ci_idx][ci_way][ci_w] <= st_merge(ci_word, cache_din, cache_u_b_h_w, cache_addr[1:0]);
      c_dirty[ci_idx][ci_way]      <= 1'b1;
    end
    if ((cache_edit || cache_load) && ci_hit) c_lru[ci_idx] <= ~ci_way;
  end

  // ---------------- memory model with transfer log ----------------
  bit [31:0]   mem    [4096];
  bit          mem_wr [4096];
  int          mem_lat = 0;
  int          mem_wait = 0;
  logic [31:0] log_addr [64];
  logic        log_we   [64];
  logic [31:0] log_data [64];
  int          log_n = 0;

  function automatic logic [31:0] mem_default(logic [31:0] a);
    if (a[31:4] == 28'h0000010) return {30'd0, a[3:2]} + 32'd1;
    return 32'hC000_0000 | {a[31:2], 2'b00};
  endfunction

  wire [31:0] mem_rd = mem_wr[mem_addr[13:2]] ? mem[mem_addr[13:2]] : mem_default(mem_addr);

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (mem_cs && !mem_ack) begin
      if (mem_wait >= mem_lat) begin
        mem_ack  <= 1'b1;
        mem_wait <= 0;
        if (log_n < 64) begin
          log_addr[log_n] <= mem_addr;
          log_we[log_n]   <= mem_we;
          log_data[log_n] <= mem_we ? mem_dout : mem_rd;
        end
        log_n <= log_n + 1;
        if (mem_we) begin
          mem[mem_addr[13:2]]    <= mem_dout;
          mem_wr[mem_addr[13:2]] <= 1'b1;
        end else begin
          mem_din <= mem_rd;
        end
      end else begin
        mem_wait <= mem_wait + 1;
      end
    end else begin
      mem_wait <= 0;
    end
  end

  // ---------------- transfer stability monitor ----------------
  logic [31:0] snap_addr, snap_dout;
  logic        snap_we;
  logic        mon_prev_cs = 1'b0, mon_prev_ack = 1'b0;
  int          mon_unstable = 0, mon_busy_bad = 0, mon_cs_cycles = 0;

  always @(negedge clk) begin
    if (mem_cs) begin
      if (!mon_prev_cs || mon_prev_ack) begin
        snap_addr <= mem_addr;
        snap_we   <= mem_we;
        snap_dout <= mem_dout;
      end else if (mem_addr !== snap_addr || mem_we !== snap_we || mem_dout !== snap_dout) begin
        mon_unstable <= mon_unstable + 1;
      end
      if (!cpu_busy) mon_busy_bad <= mon_busy_bad + 1;
      mon_cs_cycles <= mon_cs_cycles + 1;
    end
    mon_prev_cs  <= mem_cs;
    mon_prev_ack <= mem_ack;
  end

  // ---------------- request driver ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f,
                        input logic [31:0] din, output logic [31:0] dout, output int cyc);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_u_b_h_w = f; cpu_din = din;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = 32'hDEAD_BEE0; cpu_din = 32'h0BAD_0BAD;
    cyc = 1;
    while (!cpu_ack && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    dout = cpu_dout;
    checks++;
    if (!cpu_ack) begin
      errors++;
      $display("FAIL req_timeout addr=%h: no cpu_ack within %0d cycles", addr, cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_u_b_h_w = '0; cpu_din = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", cpu_ack); end
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", cpu_busy); end
    checks++; if ({mem_cs, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem got=%b exp=00", {mem_cs, mem_we}); end
    checks++;
    if ({cache_load, cache_store, cache_edit, cache_invalid} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {cache_load, cache_store, cache_edit, cache_invalid});
    end
    checks++; if (cache_addr !== 32'd0) begin errors++; $display("FAIL reset_cache_addr got=%h exp=0", cache_addr); end
    checks++; if (cpu_dout !== 32'd0) begin errors++; $display("FAIL reset_cpu_dout got=%h exp=0", cpu_dout); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_miss();
    logic [31:0] d;
    int c, s;
    s = log_n;
    do_req(1'b0, 32'h104, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL clean_miss_data got=%h exp=2", d); end
    checks++; if (c !== 13) begin errors++; $display("FAIL clean_miss_cycles got=%0d exp=13", c); end
    checks++; if (log_n - s !== 4) begin errors++; $display("FAIL clean_miss_xfers got=%0d exp=4", log_n - s); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[s+i] !== 32'h100 + 32'(4*i) || log_we[s+i] !== 1'b0 || log_data[s+i] !== 32'(i+1)) begin
        errors++;
        $display("FAIL clean_miss_xfer%0d got addr=%h we=%b data=%h exp addr=%h we=0 data=%h",
                 i, log_addr[s+i], log_we[s+i], log_data[s+i], 32'h100 + 32'(4*i), 32'(i+1));
      end
    end
  endtask

  task automatic test_hit_ext();
    logic [31:0] d;
    int c, s;
    s = log_n;
    do_req(1'b1, 32'h100, 3'b010, 32'h0000_0080, d, c);
    checks++; if (d !== 32'd0 || c !== 3) begin errors++; $display("FAIL hit_sw got dout=%h cyc=%0d exp dout=0 cyc=3", d, c); end
    do_req(1'b0, 32'h100, 3'b000, 32'd0, d, c);
    checks++; if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL hit_lb got=%h exp=ffffff80", d); end
    do_req(1'b0, 32'h100, 3'b100, 32'd0, d, c);
    checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL hit_lbu got=%h exp=00000080", d); end
    do_req(1'b1, 32'h103, 3'b000, 32'h0000_00FE, d, c);
    do_req(1'b0, 32'h100, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'hFE00_0080) begin errors++; $display("FAIL hit_sb_lw got=%h exp=fe000080", d); end
    do_req(1'b0, 32'h102, 3'b001, 32'd0, d, c);
    checks++; if (d !== 32'hFFFF_FE00) begin errors++; $display("FAIL hit_lh got=%h exp=fffffe00", d); end
    checks++; if (log_n !== s) begin errors++; $display("FAIL hit_no_mem got=%0d exp=0", log_n - s); end
  endtask

  task automatic test_hit_timing();
    logic [31:0] d;
    int c, cs0;
    cs0 = mon_cs_cycles;
    do_req(1'b0, 32'h108, 3'b010, 32'd0, d, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL hit_latency got=%0d exp=3", c); end
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL hit_data got=%h exp=3", d); end
    checks++; if (mon_cs_cycles !== cs0) begin errors++; $display("FAIL hit_mem_cs got=%0d exp=0", mon_cs_cycles - cs0); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] d;
    logic [31:0] exp_wb [4];
    int c, s;
    exp_wb[0] = 32'hAABB_CCDD; exp_wb[1] = 32'd2; exp_wb[2] = 32'd3; exp_wb[3] = 32'd4;
    do_req(1'b1, 32'h100, 3'b010, 32'hAABB_CCDD, d, c);
    do_req(1'b0, 32'h1100, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'hC000_1100 || c !== 13) begin errors++; $display("FAIL evict_first got data=%h cyc=%0d exp data=c0001100 cyc=13", d, c); end
    s = log_n;
    do_req(1'b0, 32'h2100, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'hC000_2100) begin errors++; $display("FAIL evict_data got=%h exp=c0002100", d); end
    checks++; if (c !== 25) begin errors++; $display("FAIL evict_cycles got=%0d exp=25", c); end
    checks++; if (log_n - s !== 8) begin errors++; $display("FAIL evict_xfers got=%0d exp=8", log_n - s); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[s+i] !== 32'h100 + 32'(4*i) || log_we[s+i] !== 1'b1 || log_data[s+i] !== exp_wb[i]) begin
        errors++;
        $display("FAIL evict_wb%0d got addr=%h we=%b data=%h exp addr=%h we=1 data=%h",
                 i, log_addr[s+i], log_we[s+i], log_data[s+i], 32'h100 + 32'(4*i), exp_wb[i]);
      end
      checks++;
      if (log_addr[s+4+i] !== 32'h2100 + 32'(4*i) || log_we[s+4+i] !== 1'b0) begin
        errors++;
        $display("FAIL evict_fill%0d got addr=%h we=%b exp addr=%h we=0",
                 i, log_addr[s+4+i], log_we[s+4+i], 32'h2100 + 32'(4*i));
      end
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] d;
    int c, s, u0, b0, cs0;
    do_req(1'b1, 32'h1100, 3'b010, 32'h1234_5678, d, c);
    do_req(1'b0, 32'h2104, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'hC000_2104) begin errors++; $display("FAIL stall_pre got=%h exp=c0002104", d); end
    mem_lat = 5;
    s = log_n; u0 = mon_unstable; b0 = mon_busy_bad; cs0 = mon_cs_cycles;
    do_req(1'b0, 32'h3100, 3'b010, 32'd0, d, c);
    mem_lat = 0;
    checks++; if (d !== 32'hC000_3100) begin errors++; $display("FAIL stall_data got=%h exp=c0003100", d); end
    checks++; if (mon_unstable !== u0) begin errors++; $display("FAIL stall_stable got=%0d unstable cycles exp=0", mon_unstable - u0); end
    checks++; if (mon_busy_bad !== b0) begin errors++; $display("FAIL stall_busy got=%0d idle cycles exp=0", mon_busy_bad - b0); end
    checks++; if (mon_cs_cycles - cs0 !== 56) begin errors++; $display("FAIL stall_cs_cycles got=%0d exp=56", mon_cs_cycles - cs0); end
    checks++;
    if (log_n - s !== 8 || log_addr[s] !== 32'h1100 || log_we[s] !== 1'b1 || log_data[s] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_wb0 got n=%0d addr=%h we=%b data=%h exp n=8 addr=00001100 we=1 data=12345678",
               log_n - s, log_addr[s], log_we[s], log_data[s]);
    end
    checks++; if (log_data[s+3] !== 32'hC000_110C) begin errors++; $display("FAIL stall_wb3 got=%h exp=c000110c", log_data[s+3]); end
  endtask

  task automatic test_reset_fill();
    logic [31:0] d;
    int c, s, n;
    s = log_n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h204; cpu_u_b_h_w = 3'b010;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!(mem_cs && mem_addr == 32'h208) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL rstfill_reach got no word-2 fill exp fill of 00000208"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL rstfill_mem_cs got=%b exp=0", mem_cs); end
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rstfill_busy got=%b exp=0", cpu_busy); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (log_n - s !== 2) begin errors++; $display("FAIL rstfill_xfers got=%0d exp=2", log_n - s); end
    do_req(1'b0, 32'h204, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'hC000_0204 || c !== 3) begin errors++; $display("FAIL rstfill_replay got data=%h cyc=%0d exp data=c0000204 cyc=3", d, c); end
    do_req(1'b0, 32'h200, 3'b010, 32'd0, d, c);
    checks++; if (d !== 32'hC000_0200) begin errors++; $display("FAIL rstfill_word0 got=%h exp=c0000200", d); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_clean_miss();
    test_hit_ext();
    test_hit_timing();
    test_dirty_evict();
    test_mem_stall();
    test_reset_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
